udp_mii_receive: RTL and testbench

Receive-side counterpart of the team's UDP/IP transmitter. It consumes a 4-bit MII nibble stream: preamble, SFD, Ethernet II header, IPv4 header, UDP header, payload, pad and FCS. It filters on destination MAC and IP, and delivers the UDP payload as 32-bit big-endian words with a per-frame end pulse and CRC verdict. It sits between the PHY receive pins (or the transmitter output in loopback) and the user data FIFO.

---
 rtl/eth_pkg.sv | 32 +++
 rtl/crc32_d4.sv | 32 +++
 rtl/udp_mii_receive.sv | 205 ++++++++++++++++++++
 tb/tb_udp_mii_receive.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, receive FSM states and small helpers.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;

    localparam int unsigned PREAMBLE_LEN = 7;
    localparam int unsigned ETH_HEAD_LEN = 14;
    localparam int unsigned IP_HEAD_LEN  = 20;
    localparam int unsigned UDP_HEAD_LEN = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ETH_HEAD,
        S_IP_HEAD,
        S_UDP_HEAD,
        S_DATA,
        S_TAIL,
        S_DROP
    } rx_state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc32_d4.sv
// Ethernet CRC-32, MSB-first register, one nibble per clock (bit 0 of the nibble first).
module crc32_d4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  data,
    input  logic        crc_en,
    input  logic        crc_clr,
    output logic [31:0] crc_data
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? POLY : 32'd0);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_data <= 32'hFFFF_FFFF;
        end else if (crc_clr) begin
            crc_data <= 32'hFFFF_FFFF;
        end else if (crc_en) begin
            crc_data <= crc_step(crc_data, data);
        end
    end

endmodule

// File: rtl/udp_mii_receive.sv
// MII nibble receiver: filters Ethernet/IPv4/UDP headers and emits the UDP payload as
// big-endian 32-bit words with an end-of-frame pulse and FCS verdict.
module udp_mii_receive #(
    parameter logic [47:0] BOARD_MAC = 48'h12_34_56_78_9A_BC,
    parameter logic [31:0] BOARD_IP  = {8'd169, 8'd254, 8'd1, 8'd23}
) (
    input  logic        eth_tx_clk,
    input  logic        sys_rst_n,
    input  logic        eth_rx_dv,
    input  logic [3:0]  eth_rx_data,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic [15:0] rec_data_num,
    output logic        rec_end,
    output logic        rec_crc_ok
);

    import eth_pkg::*;

    rx_state_e   state, state_next;
    logic        half;
    logic [3:0]  nib_lo;
    logic        byte_valid_c;
    logic [7:0]  rx_byte_c;
    logic [15:0] byte_cnt;
    logic        mac_uni, mac_bcast, mac_uni_c, mac_bcast_c;
    logic [15:0] udp_len, payload_len_c;
    logic [31:0] word_buf, word_next_c;
    logic        field_bad_c, emit_c, end_c, num_load_c, data_last_c;
    logic        crc_en_c, crc_clr_c;
    logic [31:0] crc_data;

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return BOARD_MAC[47:40];
            3'd1:    return BOARD_MAC[39:32];
            3'd2:    return BOARD_MAC[31:24];
            3'd3:    return BOARD_MAC[23:16];
            3'd4:    return BOARD_MAC[15:8];
            default: return BOARD_MAC[7:0];
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return BOARD_IP[31:24];
            2'd1:    return BOARD_IP[23:16];
            2'd2:    return BOARD_IP[15:8];
            default: return BOARD_IP[7:0];
        endcase
    endfunction

    // Nibble pairing: low nibble arrives first; the toggle restarts whenever dv drops.
    assign byte_valid_c = eth_rx_dv & half;
    assign rx_byte_c    = {eth_rx_data, nib_lo};

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            half   <= 1'b0;
            nib_lo <= 4'd0;
        end else if (!eth_rx_dv) begin
            half   <= 1'b0;
        end else begin
            half   <= ~half;
            if (!half) nib_lo <= eth_rx_data;
        end
    end

    assign mac_uni_c     = mac_uni & (rx_byte_c == mac_byte(byte_cnt[2:0]));
    assign mac_bcast_c   = mac_bcast & (rx_byte_c == 8'hFF);
    assign payload_len_c = (udp_len > 16'(UDP_HEAD_LEN)) ? udp_len - 16'(UDP_HEAD_LEN) : 16'd0;
    assign data_last_c   = (byte_cnt == rec_data_num - 16'd1);

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        field_bad_c = 1'b0;
        emit_c      = 1'b0;
        end_c       = 1'b0;
        num_load_c  = 1'b0;
        crc_en_c    = 1'b0;
        crc_clr_c   = 1'b0;
        case (state)
            S_IDLE: begin
                crc_clr_c = 1'b1;
                if (eth_rx_dv) state_next = (eth_rx_data == ETH_PREAMBLE[3:0]) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: if (byte_valid_c) begin
                if (byte_cnt < 16'(PREAMBLE_LEN)) field_bad_c = (rx_byte_c != ETH_PREAMBLE);
                else if (rx_byte_c == ETH_SFD)    state_next  = S_ETH_HEAD;
                else                              field_bad_c = 1'b1;
            end
            S_ETH_HEAD: begin
                crc_en_c = eth_rx_dv;
                if (byte_valid_c) begin
                    if (byte_cnt == 16'd5)  field_bad_c = !(mac_uni_c || mac_bcast_c);
                    if (byte_cnt == 16'd12) field_bad_c = (rx_byte_c != ETH_TYPE_IP[15:8]);
                    if (byte_cnt == 16'(ETH_HEAD_LEN - 1)) begin
                        field_bad_c = (rx_byte_c != ETH_TYPE_IP[7:0]);
                        state_next  = S_IP_HEAD;
                    end
                end
            end
            S_IP_HEAD: begin
                crc_en_c = eth_rx_dv;
                if (byte_valid_c) begin
                    if (byte_cnt == 16'd0) field_bad_c = (rx_byte_c != IP_VER_IHL);
                    if (byte_cnt == 16'd9) field_bad_c = (rx_byte_c != IP_PROTO_UDP);
                    if (byte_cnt >= 16'(IP_HEAD_LEN - 4))
                        field_bad_c = (rx_byte_c != ip_byte(byte_cnt[1:0]));
                    if (byte_cnt == 16'(IP_HEAD_LEN - 1)) state_next = S_UDP_HEAD;
                end
            end
            S_UDP_HEAD: begin
                crc_en_c = eth_rx_dv;
                if (byte_valid_c && byte_cnt == 16'(UDP_HEAD_LEN - 1)) begin
                    num_load_c = 1'b1;
                    state_next = (payload_len_c == 16'd0) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                crc_en_c = eth_rx_dv;
                if (byte_valid_c) begin
                    emit_c = (byte_cnt[1:0] == 2'd3) || data_last_c;
                    if (data_last_c) state_next = S_TAIL;
                end
            end
            S_TAIL: begin
                crc_en_c = eth_rx_dv;
                if (!eth_rx_dv) begin
                    end_c      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DROP: if (!eth_rx_dv) state_next = S_IDLE;
        endcase
        if (field_bad_c) state_next = S_DROP;
        // Losing dv before the tail aborts silently.
        if (!eth_rx_dv && state != S_TAIL && state != S_DROP) state_next = S_IDLE;
    end

    // Payload byte k lands in lane 3-(k mod 4); a fresh word starts zeroed.
    always_comb begin
        word_next_c = (byte_cnt[1:0] == 2'd0) ? 32'd0 : word_buf;
        case (byte_cnt[1:0])
            2'd0:    word_next_c[31:24] = rx_byte_c;
            2'd1:    word_next_c[23:16] = rx_byte_c;
            2'd2:    word_next_c[15:8]  = rx_byte_c;
            default: word_next_c[7:0]   = rx_byte_c;
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_cnt     <= 16'd0;
            mac_uni      <= 1'b1;
            mac_bcast    <= 1'b1;
            udp_len      <= 16'd0;
            word_buf     <= 32'd0;
            rec_en       <= 1'b0;
            rec_data     <= 32'd0;
            rec_data_num <= 16'd0;
            rec_end      <= 1'b0;
            rec_crc_ok   <= 1'b0;
        end else begin
            if (state_next != state) byte_cnt <= 16'd0;
            else if (byte_valid_c)   byte_cnt <= sat_inc(byte_cnt);

            if (state == S_IDLE) begin
                mac_uni   <= 1'b1;
                mac_bcast <= 1'b1;
            end else if (state == S_ETH_HEAD && byte_valid_c && byte_cnt < 16'd6) begin
                mac_uni   <= mac_uni_c;
                mac_bcast <= mac_bcast_c;
            end

            if (state == S_UDP_HEAD && byte_valid_c) begin
                if (byte_cnt == 16'd4) udp_len[15:8] <= rx_byte_c;
                if (byte_cnt == 16'd5) udp_len[7:0]  <= rx_byte_c;
            end
            if (num_load_c) rec_data_num <= payload_len_c;

            if (state == S_DATA && byte_valid_c) word_buf <= word_next_c;
            rec_en <= emit_c;
            if (emit_c) rec_data <= word_next_c;

            rec_end    <= end_c;
            rec_crc_ok <= end_c && (crc_data == CRC_RESIDUE);
        end
    end

    crc32_d4 u_crc32_d4 (
        .clk      (eth_tx_clk),
        .rst_n    (sys_rst_n),
        .data     (eth_rx_data),
        .crc_en   (crc_en_c),
        .crc_clr  (crc_clr_c),
        .crc_data (crc_data)
    );

endmodule

// File: tb/tb_udp_mii_receive.sv
// Randomized frame-level bench for udp_mii_receive against a byte-level reference model.
module tb_udp_mii_receive;

    localparam logic [47:0] MAC = 48'h12_34_56_78_9A_BC;
    localparam logic [31:0] IP  = {8'd169, 8'd254, 8'd1, 8'd23};

    logic        eth_tx_clk = 1'b0;
    logic        sys_rst_n;
    logic        eth_rx_dv;
    logic [3:0]  eth_rx_data;
    logic        rec_en;
    logic [31:0] rec_data;
    logic [15:0] rec_data_num;
    logic        rec_end;
    logic        rec_crc_ok;

    always #5 eth_tx_clk = ~eth_tx_clk;

    udp_mii_receive #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
        .eth_tx_clk   (eth_tx_clk),
        .sys_rst_n    (sys_rst_n),
        .eth_rx_dv    (eth_rx_dv),
        .eth_rx_data  (eth_rx_data),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_data_num (rec_data_num),
        .rec_end      (rec_end),
        .rec_crc_ok   (rec_crc_ok)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled 2ns after the rising edge.
    logic [31:0] got_w[$];
    int          got_end;
    logic        got_crc;

    always @(posedge eth_tx_clk) begin
        #2;
        if (rec_en) got_w.push_back(rec_data);
        if (rec_end) begin
            got_end++;
            got_crc = rec_crc_ok;
        end
    end

    logic [7:0]  frm[$];
    logic [7:0]  pl[$];
    logic [15:0] exp_num = 16'd0;

    // Standard reflected Ethernet CRC over frm[from..to-1], no final inversion.
    function automatic logic [31:0] crc_ref(input int from, input int to);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = from; i < to; i++) begin
            c ^= {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic push16(input int v);
        frm.push_back(8'(v >> 8));
        frm.push_back(8'(v));
    endtask

    // mode: 0 unicast, 1 broadcast, 2 bad MAC, 3 bad type, 4 bad ver/IHL,
    //       5 bad protocol, 6 wrong dest IP, 7 bad preamble byte, 8 bit flip after FCS
    task automatic build(input int pad, input int mode);
        logic [31:0] fcs;
        int          idx;
        frm = {};
        for (int i = 0; i < 7; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 0; i < 6; i++) frm.push_back(mode == 1 ? 8'hFF : MAC[47-8*i -: 8]);
        if (mode == 2) frm[8 + $urandom_range(0, 5)] ^= 8'h01;
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        push16(mode == 3 ? 16'h0806 : 16'h0800);
        frm.push_back(mode == 4 ? 8'h46 : 8'h45);
        frm.push_back(8'h00);
        push16(28 + pl.size());
        push16(int'($urandom_range(0, 65535)));
        push16(16'h4000);
        frm.push_back(8'h40);
        frm.push_back(mode == 5 ? 8'd6 : 8'd17);
        push16(0);
        for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) frm.push_back(IP[31-8*i -: 8] + ((mode == 6 && i == 3) ? 8'd1 : 8'd0));
        push16(int'($urandom_range(0, 65535)));
        push16(int'($urandom_range(0, 65535)));
        push16(8 + pl.size());
        push16(0);
        foreach (pl[i]) frm.push_back(pl[i]);
        for (int i = 0; i < pad; i++) frm.push_back(8'($urandom));
        fcs = ~crc_ref(8, frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (mode == 7) frm[5] = 8'h54;
        if (mode == 8) begin
            idx = int'($urandom_range(50, frm.size() - 1));
            frm[idx] ^= 8'(1 << $urandom_range(0, 7));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},  32'(rec_en),       32'd0);
        check({tag, "_dat"}, rec_data,          32'd0);
        check({tag, "_num"}, 32'(rec_data_num), 32'd0);
        check({tag, "_end"}, 32'(rec_end),      32'd0);
        check({tag, "_crc"}, 32'(rec_crc_ok),   32'd0);
    endtask

    // Drive frm[0..cut-1] (reset pulsed at byte rst_at when >= 0) and compare with the model.
    task automatic run_frame(input string tag, input int cut, input int rst_at, input int gap);
        logic [31:0] exp_w[$];
        logic [31:0] w = 32'd0;
        bit          hdr_ok, exp_end, exp_crc;
        int          plen, p;
        hdr_ok = 1'b1;
        for (int i = 0; i < 7; i++) if (frm[i] != 8'h55) hdr_ok = 1'b0;
        if (frm[7] != 8'hD5) hdr_ok = 1'b0;
        begin
            bit uni = 1'b1, bc = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (frm[8+i] != MAC[47-8*i -: 8]) uni = 1'b0;
                if (frm[8+i] != 8'hFF) bc = 1'b0;
            end
            if (!(uni || bc)) hdr_ok = 1'b0;
        end
        if (frm[20] != 8'h08 || frm[21] != 8'h00 || frm[22] != 8'h45 || frm[31] != 8'd17) hdr_ok = 1'b0;
        for (int i = 0; i < 4; i++) if (frm[38+i] != IP[31-8*i -: 8]) hdr_ok = 1'b0;
        plen    = int'({frm[46], frm[47]}) - 8;
        exp_end = 1'b0;
        exp_crc = 1'b0;
        if (rst_at >= 0) begin
            exp_num = 16'd0;
        end else if (hdr_ok && cut >= 50) begin
            exp_num = 16'(plen);
            p = (cut - 50 < plen) ? cut - 50 : plen;
            for (int i = 0; i < p; i++) begin
                if (i % 4 == 0) w = 32'd0;
                w[31 - 8*(i%4) -: 8] = frm[50+i];
                if (i % 4 == 3 || i == plen - 1) exp_w.push_back(w);
            end
            exp_end = (cut >= 50 + plen);
            exp_crc = (crc_ref(8, cut) == 32'hDEBB_20E3);
        end

        got_w   = {};
        got_end = 0;
        got_crc = 1'b0;
        for (int i = 0; i < cut; i++) begin
            for (int h = 0; h < 2; h++) begin
                @(negedge eth_tx_clk);
                if (i == rst_at && h == 0) begin
                    sys_rst_n = 1'b0;
                    #1;
                    check_reset_outputs({tag, "_midrst"});
                    #3;
                    sys_rst_n = 1'b1;
                end
                eth_rx_dv   = 1'b1;
                eth_rx_data = (h == 1) ? frm[i][7:4] : frm[i][3:0];
            end
        end
        @(negedge eth_tx_clk);
        eth_rx_dv   = 1'b0;
        eth_rx_data = 4'd0;
        @(negedge eth_tx_clk);

        check({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s_word%0d", tag, i), got_w[i], exp_w[i]);
        check({tag, "_end"}, 32'(got_end), exp_end ? 32'd1 : 32'd0);
        if (exp_end && got_end > 0) check({tag, "_crc"}, 32'(got_crc), 32'(exp_crc));
        check({tag, "_num"}, 32'(rec_data_num), 32'(exp_num));
        for (int i = 1; i < gap; i++) @(negedge eth_tx_clk);
    endtask

    task automatic set_http();
        logic [7:0] http[10] = '{8'h68, 8'h74, 8'h74, 8'h70, 8'h3a, 8'h2f, 8'h2f, 8'h77, 8'h77, 8'h77};
        pl = {};
        foreach (http[i]) pl.push_back(http[i]);
    endtask

    task automatic set_random(input int n);
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        eth_rx_dv   = 1'b0;
        eth_rx_data = 4'd0;
        repeat (3) @(negedge eth_tx_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        @(negedge eth_tx_clk);

        set_http();
        build(4, 1);
        run_frame("http", frm.size(), -1, 1);
        check("http_w0", got_w.size() > 0 ? got_w[0] : 32'hX, 32'h6874_7470);
        check("http_w1", got_w.size() > 1 ? got_w[1] : 32'hX, 32'h3a2f_2f77);
        check("http_w2", got_w.size() > 2 ? got_w[2] : 32'hX, 32'h7777_0000);
        check("http_num", 32'(rec_data_num), 32'd10);
        check("http_ok", 32'(got_crc), 32'd1);

        frm[55] ^= 8'h01;
        run_frame("flip", frm.size(), -1, 1);
        check("flip_w1", got_w.size() > 1 ? got_w[1] : 32'hX, 32'h3a2e_2f77);
        check("flip_ok", 32'(got_crc), 32'd0);

        build(0, 6);
        run_frame("badip", frm.size(), -1, 1);
        set_random(7);
        build(3, 0);
        run_frame("afterip", frm.size(), -1, 1);

        build(2, 7);
        run_frame("badpre", frm.size(), -1, 2);
        build(2, 0);
        run_frame("afterpre", frm.size(), -1, 1);

        set_http();
        build(0, 0);
        run_frame("trunc", 56, -1, 2);

        set_random(12);
        build(1, 0);
        run_frame("midrst", frm.size(), 30, 2);
        set_random(5);
        build(0, 1);
        run_frame("afterrst", frm.size(), -1, 1);
        check("afterrst_ok", 32'(got_crc), 32'd1);

        for (int n = 0; n < 60; n++) begin
            int mode, cut;
            set_random(int'($urandom_range(0, 24)));
            mode = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 8));
            build(int'($urandom_range(0, 6)), mode);
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, frm.size() - 1)) : frm.size();
            run_frame($sformatf("rnd%0d_m%0d", n, mode), cut, -1, int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
